// File: rtl/pc_gen.sv
// Fetch-address generator ahead of IF: sequential PC+4 or trap/branch redirect,
// with a wrong-path kill and a flag for misaligned redirect targets.
module pc_gen #(
  parameter int unsigned            ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  decode_ready_i,
  input  logic                  trap_valid_i,
  input  logic [ADDR_WIDTH-1:0] trap_pc_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  kill_o,
  output logic                  misaligned_o,
  output logic [ADDR_WIDTH-1:0] misaligned_addr_o,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  mis_q, mis_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;

  logic                  redir;
  logic                  take;
  logic [ADDR_WIDTH-1:0] tgt;

  // Trap outranks branch redirect; BOOT ignores both.
  assign redir = trap_valid_i | redirect_valid_i;
  assign tgt   = trap_valid_i ? trap_pc_i : redirect_pc_i;
  assign take  = redir && (state_q != BOOT);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= BOOT;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (take) state_d = FLUSH;
      FLUSH: begin
        if (take)                state_d = FLUSH;
        else if (decode_ready_i) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  // Output logic
  always_comb begin
    pc_o    = pc_q;
    kill_o  = redir;
    state_o = state_q;
    unique case (state_q)
      BOOT:    begin pc_o = RESET_VECTOR; kill_o = 1'b1; end
      RUN:     ;
      FLUSH:   kill_o = 1'b1;
      default: begin pc_o = RESET_VECTOR; kill_o = 1'b1; end
    endcase
  end

  // PC and misalignment datapath
  always_comb begin
    pc_d    = pc_q;
    mis_d   = 1'b0;
    maddr_d = maddr_q;
    if (take) begin
      pc_d  = {tgt[ADDR_WIDTH-1:2], 2'b00};
      mis_d = |tgt[1:0];
      if (|tgt[1:0]) maddr_d = tgt;
    end else if (state_q != BOOT && decode_ready_i) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= RESET_VECTOR;
      mis_q   <= 1'b0;
      maddr_q <= '0;
    end else begin
      pc_q    <= pc_d;
      mis_q   <= mis_d;
      maddr_q <= maddr_d;
    end
  end

  assign misaligned_o      = mis_q;
  assign misaligned_addr_o = maddr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: per-cycle expected outputs queued by stimulus,
// checked by an independent negedge monitor.
module tb_pc_gen;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, rdy, tv, rv;
  logic [W-1:0] tpc, rpc;
  logic [W-1:0] pc, maddr;
  logic         kill, mis;
  logic [1:0]   st;

  typedef struct {
    logic [W-1:0] pc;
    logic         kill;
    logic         mis;
    logic [W-1:0] maddr;
    logic [1:0]   st;
    int           id;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_gen #(.ADDR_WIDTH(W), .RESET_VECTOR(32'h100)) dut (
    .clk_i(clk), .rst_i(rst), .decode_ready_i(rdy),
    .trap_valid_i(tv), .trap_pc_i(tpc),
    .redirect_valid_i(rv), .redirect_pc_i(rpc),
    .pc_o(pc), .kill_o(kill), .misaligned_o(mis),
    .misaligned_addr_o(maddr), .state_o(st)
  );

  task automatic chk(input string nm, input int id, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step%0d: got %h want %h", nm, id, act, exp);
    end
  endtask

  // Monitor: every cycle with a queued expectation, compare the visible outputs.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc",    e.id, pc,             e.pc);
      chk("kill",  e.id, W'(kill),       W'(e.kill));
      chk("mis",   e.id, W'(mis),        W'(e.mis));
      chk("maddr", e.id, maddr,          e.maddr);
      chk("state", e.id, W'(st),         W'(e.st));
    end
  end

  int sid = 0;

  // Apply inputs just after the edge; expectation describes outputs in this cycle.
  task automatic step(input logic r, input logic t, input logic [W-1:0] tp,
                      input logic v, input logic [W-1:0] vp, input logic d,
                      input logic [W-1:0] epc, input logic ek, input logic em,
                      input logic [W-1:0] ema, input logic [1:0] est, input bit do_chk);
    exp_t e;
    @(posedge clk); #1;
    rst = r; tv = t; tpc = tp; rv = v; rpc = vp; rdy = d;
    sid++;
    if (do_chk) begin
      e.pc = epc; e.kill = ek; e.mis = em; e.maddr = ema; e.st = est; e.id = sid;
      q.push_back(e);
    end
  endtask

  initial begin
    rst = 1; rdy = 1; tv = 0; rv = 0; tpc = '0; rpc = '0;
    //    rst trap tpc          rv rpc          rdy  pc            k  m  maddr         st chk
    step(1, 0, 0,            0, 0,            1,   0,            0, 0, 0,            0, 0);
    step(1, 0, 0,            0, 0,            1,   32'h100,      1, 0, 0,            0, 1);
    step(0, 0, 0,            0, 0,            1,   32'h100,      1, 0, 0,            0, 1);
    step(0, 0, 0,            0, 0,            1,   32'h100,      0, 0, 0,            1, 1);
    step(0, 0, 0,            0, 0,            1,   32'h104,      0, 0, 0,            1, 1);
    step(0, 0, 0,            0, 0,            1,   32'h108,      0, 0, 0,            1, 1);
    // branch redirect with ready
    step(0, 0, 0,            1, 32'h2000,     1,   32'h10C,      1, 0, 0,            1, 1);
    step(0, 0, 0,            0, 0,            1,   32'h2000,     1, 0, 0,            2, 1);
    step(0, 0, 0,            0, 0,            0,   32'h2004,     0, 0, 0,            1, 1);
    // redirect under stall
    step(0, 0, 0,            1, 32'h400,      0,   32'h2004,     1, 0, 0,            1, 1);
    step(0, 0, 0,            0, 0,            0,   32'h400,      1, 0, 0,            2, 1);
    step(0, 0, 0,            0, 0,            0,   32'h400,      1, 0, 0,            2, 1);
    step(0, 0, 0,            0, 0,            0,   32'h400,      1, 0, 0,            2, 1);
    step(0, 0, 0,            0, 0,            1,   32'h400,      1, 0, 0,            2, 1);
    step(0, 0, 0,            0, 0,            1,   32'h404,      0, 0, 0,            1, 1);
    // trap beats redirect
    step(0, 1, 32'h80,       1, 32'h500,      1,   32'h408,      1, 0, 0,            1, 1);
    step(0, 0, 0,            0, 0,            1,   32'h80,       1, 0, 0,            2, 1);
    step(0, 0, 0,            0, 0,            1,   32'h84,       0, 0, 0,            1, 1);
    // misaligned redirect
    step(0, 0, 0,            1, 32'h1006,     1,   32'h88,       1, 0, 0,            1, 1);
    step(0, 0, 0,            0, 0,            1,   32'h1004,     1, 1, 32'h1006,     2, 1);
    step(0, 0, 0,            0, 0,            1,   32'h1008,     0, 0, 32'h1006,     1, 1);
    // back-to-back redirects while in FLUSH, misaligned trap
    step(0, 0, 0,            1, 32'h3000,     0,   32'h100C,     1, 0, 32'h1006,     1, 1);
    step(0, 1, 32'h4002,     0, 0,            0,   32'h3000,     1, 0, 32'h1006,     2, 1);
    step(0, 0, 0,            0, 0,            0,   32'h4000,     1, 1, 32'h4002,     2, 1);
    step(0, 0, 0,            0, 0,            0,   32'h4000,     1, 0, 32'h4002,     2, 1);
    // wrap at top of address space
    step(0, 0, 0,            1, 32'hFFFFFFFC, 1,   32'h4000,     1, 0, 32'h4002,     2, 1);
    step(0, 0, 0,            0, 0,            1,   32'hFFFFFFFC, 1, 0, 32'h4002,     2, 1);
    step(0, 0, 0,            0, 0,            1,   32'h0,        0, 0, 32'h4002,     1, 1);
    // reset mid-FLUSH, then redirect ignored in BOOT
    step(0, 0, 0,            1, 32'h600,      1,   32'h4,        1, 0, 32'h4002,     1, 1);
    step(1, 0, 0,            1, 32'h700,      1,   32'h600,      1, 0, 32'h4002,     2, 1);
    step(0, 0, 0,            1, 32'h806,      1,   32'h100,      1, 0, 0,            0, 1);
    step(0, 0, 0,            0, 0,            1,   32'h100,      0, 0, 0,            1, 1);
    step(0, 0, 0,            0, 0,            1,   32'h104,      0, 0, 0,            1, 1);
    begin : drain
      int n;
      n = 0;
      while (q.size() > 0 && n < 20) begin @(posedge clk); n++; end
      if (q.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
